// File: rtl/isr_gen_pkg.sv
// rtl/isr_gen_pkg.sv - shared types and width constants for the isr timebase
package isr_gen_pkg;

    typedef enum logic {IDLE, RUN} isr_state_t;

    localparam int MIN_PERIOD         = 2;
    localparam int DEF_CNT_WIDTH      = 32;
    localparam int DEF_PRESCALE_WIDTH = 8;
    localparam int DEF_OVR_WIDTH      = 16;

endpackage

// File: rtl/isr_timer_core_if.sv
// rtl/isr_timer_core_if.sv - register-file side controls and status of the isr timebase
interface isr_timer_core_if
    import isr_gen_pkg::*;
#(
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH,
    parameter int OVR_WIDTH      = DEF_OVR_WIDTH
);
    logic                      enable_i;
    logic [CNT_WIDTH-1:0]      period_i;
    logic [PRESCALE_WIDTH-1:0] prescale_i;
    logic                      sync_i;
    logic                      irq_ack_i;
    logic                      irq_o;
    logic                      tick_o;
    logic [CNT_WIDTH-1:0]      count_o;
    logic                      pending_o;
    logic [OVR_WIDTH-1:0]      overrun_cnt_o;

    modport master (
        output enable_i, period_i, prescale_i, sync_i, irq_ack_i,
        input  irq_o, tick_o, count_o, pending_o, overrun_cnt_o
    );

    modport slave (
        input  enable_i, period_i, prescale_i, sync_i, irq_ack_i,
        output irq_o, tick_o, count_o, pending_o, overrun_cnt_o
    );
endinterface

// File: rtl/isr_prescaler.sv
// rtl/isr_prescaler.sv - clock-enable divider, ce every prescale_i+1 clocks while running
module isr_prescaler #(
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      run_i,
    input  logic                      clr_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic                      ce_o
);
    logic [PRESCALE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
    logic                      armed_q, armed_d;

    // armed_q holds off the first run cycle so count_o shows 0 for one full cycle after enable
    always_comb begin
        armed_d   = run_i;
        pre_cnt_d = pre_cnt_q;
        ce_o      = 1'b0;
        if (!run_i || clr_i) begin
            pre_cnt_d = '0;
        end else if (armed_q) begin
            ce_o      = (pre_cnt_q == prescale_i);
            pre_cnt_d = ce_o ? '0 : pre_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pre_cnt_q <= '0;
            armed_q   <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            armed_q   <= armed_d;
        end
    end
endmodule

// File: rtl/isr_timer_core.sv
// rtl/isr_timer_core.sv - periodic interrupt timebase; ISR_OVERRUN_COUNT_EN enables the overrun counter
module isr_timer_core
    import isr_gen_pkg::*;
#(
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH,
    parameter int OVR_WIDTH      = DEF_OVR_WIDTH
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    isr_timer_core_if.slave  bus
);
    isr_state_t           state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] period_clamped;
    logic                 tick_q, tick_d;
    logic                 irq_q, irq_d;
    logic                 run;
    logic                 ce;

    assign period_clamped = (bus.period_i < CNT_WIDTH'(MIN_PERIOD)) ? CNT_WIDTH'(MIN_PERIOD) : bus.period_i;
    assign run            = (state_q == RUN) && bus.enable_i;

    isr_prescaler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_prescaler (
        .clk        (ACLK),
        .resetn     (ARESETN),
        .run_i      (run),
        .clr_i      (bus.sync_i),
        .prescale_i (bus.prescale_i),
        .ce_o       (ce)
    );

    // enable_i falling beats sync_i; sync_i beats a due wrap
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        period_d = period_q;
        tick_d   = 1'b0;
        if (state_q == IDLE) begin
            count_d = '0;
            if (bus.enable_i) begin
                state_d  = RUN;
                period_d = period_clamped;
            end
        end else if (!bus.enable_i) begin
            state_d = IDLE;
            count_d = '0;
        end else if (bus.sync_i) begin
            count_d = '0;
        end else if (ce) begin
            if (count_q == period_q - 1'b1) begin
                count_d  = '0;
                tick_d   = 1'b1;
                period_d = period_clamped;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
        irq_d = irq_q;
        if (tick_d) begin
            irq_d = 1'b1;
        end else if (bus.irq_ack_i) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q  <= IDLE;
            count_q  <= '0;
            period_q <= '0;
            tick_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            tick_q   <= tick_d;
            irq_q    <= irq_d;
        end
    end

`ifdef ISR_OVERRUN_COUNT_EN
    logic [OVR_WIDTH-1:0] ovr_q, ovr_d;

    // an ack with nothing pending is the software's way to clear the overrun tally
    always_comb begin
        ovr_d = ovr_q;
        if (bus.irq_ack_i && !irq_q) begin
            ovr_d = '0;
        end else if (tick_d && irq_q && !bus.irq_ack_i && (ovr_q != '1)) begin
            ovr_d = ovr_q + 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign bus.overrun_cnt_o = ovr_q;
`else
    assign bus.overrun_cnt_o = '0;
`endif

    assign bus.irq_o     = irq_q;
    assign bus.pending_o = irq_q;
    assign bus.tick_o    = tick_q;
    assign bus.count_o   = count_q;
endmodule

// File: tb/tb_isr_timer_core.sv
// tb/tb_isr_timer_core.sv - directed and random checks of isr_timer_core against a behavioural model
module tb_isr_timer_core;
    localparam int CW = 32;
    localparam int PW = 8;
    localparam int OW = 16;

    logic clk = 1'b0;
    logic rstn;
    int   n_vec = 0;
    int   n_err = 0;

    isr_timer_core_if #(.CNT_WIDTH(CW), .PRESCALE_WIDTH(PW), .OVR_WIDTH(OW)) bus ();

    isr_timer_core #(.CNT_WIDTH(CW), .PRESCALE_WIDTH(PW), .OVR_WIDTH(OW)) dut (
        .ACLK    (clk),
        .ARESETN (rstn),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // behavioural reference state
    bit          m_run, m_first, m_irq, m_tick;
    int unsigned m_pre, m_cnt, m_per, m_ovr;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit irq_old;
        m_tick = 0;
        if (!rstn) begin
            m_run = 0; m_first = 1; m_pre = 0; m_cnt = 0; m_per = 0; m_irq = 0; m_ovr = 0;
            return;
        end
        irq_old = m_irq;
        if (!m_run) begin
            if (bus.enable_i) begin
                m_run = 1; m_per = (bus.period_i < 2) ? 2 : bus.period_i; m_cnt = 0; m_pre = 0;
            end
            m_first = 1;
        end else if (!bus.enable_i) begin
            m_run = 0; m_cnt = 0; m_pre = 0; m_first = 1;
        end else if (bus.sync_i) begin
            m_cnt = 0; m_pre = 0; m_first = 0;
        end else begin
            // the first clock after enable only arms the divider
            if (!m_first) begin
                if (m_pre == bus.prescale_i) begin
                    m_pre = 0;
                    if (m_cnt == m_per - 1) begin
                        m_cnt = 0; m_tick = 1; m_per = (bus.period_i < 2) ? 2 : bus.period_i;
                    end else begin
                        m_cnt++;
                    end
                end else begin
                    m_pre = (m_pre + 1) % 256;
                end
            end
            m_first = 0;
        end
        if (bus.irq_ack_i && !irq_old) m_ovr = 0;
        if (m_tick) begin
            if (irq_old && !bus.irq_ack_i && m_ovr < 65535) m_ovr++;
            m_irq = 1;
        end else if (bus.irq_ack_i) begin
            m_irq = 0;
        end
    endtask

    function automatic int exp_ovr();
`ifdef ISR_OVERRUN_COUNT_EN
        return m_ovr;
`else
        return 0;
`endif
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("irq", bus.irq_o, m_irq);
        check("tick", bus.tick_o, m_tick);
        check("count", bus.count_o, m_cnt);
        check("pending", bus.pending_o, m_irq);
        check("overrun", bus.overrun_cnt_o, exp_ovr());
    endtask

    task automatic wait_tick(input string tag, input int limit, output int cycles);
        cycles = 0;
        do begin
            cyc();
            cycles++;
        end while (!bus.tick_o && cycles < limit);
        if (!bus.tick_o) check({tag, "_timeout"}, cycles, -1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.enable_i = 0; bus.sync_i = 0; bus.irq_ack_i = 0;
        repeat (2) cyc();
        rstn = 1'b1;
    endtask

    task automatic pulse_ack();
        bus.irq_ack_i = 1; cyc(); bus.irq_ack_i = 0;
    endtask

    initial begin
        int c;
        rstn = 0;
        bus.enable_i = 0; bus.period_i = 0; bus.prescale_i = 0; bus.sync_i = 0; bus.irq_ack_i = 0;
        do_reset();
        check("rst_irq", bus.irq_o, 0);
        check("rst_count", bus.count_o, 0);
        check("rst_ovr", bus.overrun_cnt_o, 0);

        // T1: period 4, prescale 0 -> ticks at enable+5, +9, +13
        bus.period_i = 4; bus.enable_i = 1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            wait_tick("t1", 20, c);
            check("t1_tick_gap", c, (k == 0) ? 5 : 4);
        end

        // T2: period 0 and 1 behave as 2
        for (int p = 0; p < 2; p++) begin
            bus.enable_i = 0; cyc();
            bus.period_i = p; bus.enable_i = 1; cyc();
            wait_tick("t2a", 20, c);
            wait_tick("t2b", 20, c);
            check("t2_gap", c, 2);
        end

        // T3: two unacknowledged ticks after irq is set
        do_reset();
        bus.period_i = 3; bus.enable_i = 1; cyc();
        wait_tick("t3a", 20, c);
        wait_tick("t3b", 20, c);
        wait_tick("t3c", 20, c);
        check("t3_irq", bus.irq_o, 1);
`ifdef ISR_OVERRUN_COUNT_EN
        check("t3_ovr", bus.overrun_cnt_o, 2);
`else
        check("t3_ovr", bus.overrun_cnt_o, 0);
`endif

        // T4: ack coinciding with a tick keeps irq, next ack clears it
        bus.period_i = 2;
        wait_tick("t4a", 20, c);
        wait_tick("t4b", 20, c);
        cyc();
        bus.irq_ack_i = 1; cyc(); bus.irq_ack_i = 0;
        check("t4_tick", bus.tick_o, 1);
        check("t4_irq_held", bus.irq_o, 1);
        pulse_ack();
        check("t4_irq_clr", bus.irq_o, 0);

        // T5: prescale 3 period 5, then period 2 taking effect at a wrap
        bus.enable_i = 0; cyc();
        bus.prescale_i = 3; bus.period_i = 5; bus.enable_i = 1; cyc();
        wait_tick("t5a", 50, c);
        wait_tick("t5b", 50, c);
        check("t5_gap20", c, 20);
        repeat (7) cyc();
        bus.period_i = 2;
        wait_tick("t5c", 50, c);
        check("t5_old_finish", c, 13);
        wait_tick("t5d", 50, c);
        check("t5_gap8", c, 8);

        // T6: sync at count 3 of period 4, then disable mid-count
        bus.enable_i = 0; cyc();
        bus.prescale_i = 0; bus.period_i = 4; bus.enable_i = 1; cyc();
        wait_tick("t6a", 20, c);
        repeat (3) cyc();
        check("t6_cnt3", bus.count_o, 3);
        bus.sync_i = 1; cyc(); bus.sync_i = 0;
        check("t6_sync_cnt", bus.count_o, 0);
        check("t6_sync_tick", bus.tick_o, 0);
        wait_tick("t6b", 20, c);
        check("t6_gap", c, 4);
        repeat (2) cyc();
        bus.enable_i = 0; cyc();
        check("t6_dis_cnt", bus.count_o, 0);
        check("t6_dis_irq", bus.irq_o, 1);

        // random traffic against the model
        bus.enable_i = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(99) < 2) bus.enable_i = ~bus.enable_i;
            if ($urandom_range(99) < 5) bus.period_i = $urandom_range(7);
            if ($urandom_range(99) < 3) bus.prescale_i = ($urandom_range(9) == 0) ? PW'($urandom) : PW'($urandom_range(3));
            bus.sync_i    = ($urandom_range(99) < 3);
            bus.irq_ack_i = ($urandom_range(99) < 6);
            rstn          = !($urandom_range(999) < 3);
            cyc();
        end
        bus.sync_i = 0; bus.irq_ack_i = 0; rstn = 1;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
